// File: rtl/seg_mult_pkg.sv
// Shared types and width helpers for the segmented sequential multiplier.
// Width helpers keep every select/shift port at least one bit wide.
package seg_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nseg_of(input int width, input int seg);
    return width / seg;
  endfunction

  function automatic int sel_width(input int nseg);
    return (nseg > 1) ? $clog2(nseg) : 1;
  endfunction

  // shift_sel spans 0 .. 2*NSEG-2
  function automatic int shift_width(input int nseg);
    return ((2 * nseg - 1) > 1) ? $clog2(2 * nseg - 1) : 1;
  endfunction

endpackage

// File: rtl/seg_mult_ctrl.sv
// Sequencer for the segmented multiplier: IDLE/RUN/DONE FSM plus the
// segment-pair counters that walk (sel_a, sel_b) with sel_b innermost.
module seg_mult_ctrl
  import seg_mult_pkg::*;
#(
  parameter int NSEG = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          run,
  output logic                          accept,
  output logic                          last_step,
  output logic [sel_width(NSEG)-1:0]    sel_a,
  output logic [sel_width(NSEG)-1:0]    sel_b,
  output logic [shift_width(NSEG)-1:0]  shift_sel
);

  localparam int SW  = sel_width(NSEG);
  localparam int SHW = shift_width(NSEG);
  localparam logic [SW-1:0] LAST_SEL = SW'(NSEG - 1);

  state_t          state_reg, state_next;
  logic [SW-1:0]   sel_a_reg, sel_a_next;
  logic [SW-1:0]   sel_b_reg, sel_b_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_a_reg <= '0;
      sel_b_reg <= '0;
    end else begin
      state_reg <= state_next;
      sel_a_reg <= sel_a_next;
      sel_b_reg <= sel_b_next;
    end
  end

  // Counters return to zero on the final step, so they read 0 outside RUN.
  always_comb begin
    state_next = state_reg;
    sel_a_next = sel_a_reg;
    sel_b_next = sel_b_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          sel_a_next = '0;
          sel_b_next = '0;
        end
      end
      RUN: begin
        if (sel_b_reg == LAST_SEL) begin
          sel_b_next = '0;
          if (sel_a_reg == LAST_SEL) begin
            sel_a_next = '0;
            state_next = DONE;
          end else begin
            sel_a_next = sel_a_reg + 1'b1;
          end
        end else begin
          sel_b_next = sel_b_reg + 1'b1;
        end
      end
      DONE: state_next = IDLE;
      default: begin
        state_next = IDLE;
        sel_a_next = '0;
        sel_b_next = '0;
      end
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign run       = (state_reg == RUN);
  assign accept    = (state_reg == IDLE) && start;
  assign last_step = run && (sel_a_reg == LAST_SEL) && (sel_b_reg == LAST_SEL);
  assign sel_a     = sel_a_reg;
  assign sel_b     = sel_b_reg;
  assign shift_sel = SHW'(sel_a_reg) + SHW'(sel_b_reg);

endmodule

// File: rtl/seg_mult_seq.sv
// WIDTH x WIDTH unsigned multiplier that reuses one SEG x SEG multiplier,
// accumulating one shifted partial product per cycle.
module seg_mult_seq
  import seg_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [WIDTH-1:0]                       a,
  input  logic [WIDTH-1:0]                       b,
  output logic                                   busy,
  output logic                                   done,
  output logic [2*WIDTH-1:0]                     product,
  output logic [sel_width(WIDTH/SEG)-1:0]        sel_a,
  output logic [sel_width(WIDTH/SEG)-1:0]        sel_b,
  output logic [shift_width(WIDTH/SEG)-1:0]      shift_sel
);

  localparam int NSEG = nseg_of(WIDTH, SEG);
  localparam int PW   = 2 * WIDTH;

  generate
    if ((SEG < 1) || ((WIDTH % SEG) != 0)) begin : g_bad_params
      $error("seg_mult_seq: WIDTH must be a positive multiple of SEG");
    end
  endgenerate

  logic              run, accept, last_step;
  logic [WIDTH-1:0]  a_reg, b_reg;
  logic [PW-1:0]     acc_reg, product_reg;
  logic [SEG-1:0]    a_seg [NSEG];
  logic [SEG-1:0]    b_seg [NSEG];
  logic [SEG-1:0]    a_cur, b_cur;
  logic [2*SEG-1:0]  pp;
  logic [PW-1:0]     pp_shifted, acc_sum;

  seg_mult_ctrl #(
    .NSEG(NSEG)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .run       (run),
    .accept    (accept),
    .last_step (last_step),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .shift_sel (shift_sel)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_seg
      assign a_seg[gi] = a_reg[gi*SEG +: SEG];
      assign b_seg[gi] = b_reg[gi*SEG +: SEG];
    end
  endgenerate

  assign a_cur      = a_seg[sel_a];
  assign b_cur      = b_seg[sel_b];
  assign pp         = {{SEG{1'b0}}, a_cur} * {{SEG{1'b0}}, b_cur};
  assign pp_shifted = PW'(pp) << (shift_sel * SEG);
  assign acc_sum    = acc_reg + pp_shifted;

  // product loads on the last RUN step so it is already valid during DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      product_reg <= '0;
    end else if (accept) begin
      a_reg   <= a;
      b_reg   <= b;
      acc_reg <= '0;
    end else if (run) begin
      acc_reg <= acc_sum;
      if (last_step) begin
        product_reg <= acc_sum;
      end
    end
  end

  assign product = product_reg;

endmodule

// File: tb/tb_seg_mult_seq.sv
// Scoreboarded bench for seg_mult_seq at 8/4, 12/4 and 8/8 configurations.
module tb_seg_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] prod;
    int          cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q12[$];
  exp_t q88[$];

  logic rst;

  // 8/4 instance
  logic        start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic [0:0]  sela8, selb8;
  logic [1:0]  shift8;

  // 12/4 instance
  logic        start12, busy12, done12;
  logic [11:0] a12, b12;
  logic [23:0] prod12;
  logic [1:0]  sela12, selb12;
  logic [2:0]  shift12;

  // 8/8 instance
  logic        start88, busy88, done88;
  logic [7:0]  a88, b88;
  logic [15:0] prod88;
  logic [0:0]  sela88, selb88;
  logic [0:0]  shift88;

  seg_mult_seq #(.WIDTH(8), .SEG(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8),
    .sel_a(sela8), .sel_b(selb8), .shift_sel(shift8)
  );

  seg_mult_seq #(.WIDTH(12), .SEG(4)) dut12 (
    .clk(clk), .rst(rst), .start(start12), .a(a12), .b(b12),
    .busy(busy12), .done(done12), .product(prod12),
    .sel_a(sela12), .sel_b(selb12), .shift_sel(shift12)
  );

  seg_mult_seq #(.WIDTH(8), .SEG(8)) dut88 (
    .clk(clk), .rst(rst), .start(start88), .a(a88), .b(b88),
    .busy(busy88), .done(done88), .product(prod88),
    .sel_a(sela88), .sel_b(selb88), .shift_sel(shift88)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, want);
  endfunction

  // Monitors: every done pulse must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_checks++;
        $display("FAIL done8_unexpected at cycle %0d: got done, want no pending op", cyc);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("product8", 64'(prod8), 64'(e.prod));
        chk("done8_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (done12 === 1'b1) begin
      if (q12.size() == 0) begin
        n_checks++;
        $display("FAIL done12_unexpected at cycle %0d: got done, want no pending op", cyc);
      end else begin
        exp_t e;
        e = q12.pop_front();
        chk("product12", 64'(prod12), 64'(e.prod));
        chk("done12_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (done88 === 1'b1) begin
      if (q88.size() == 0) begin
        n_checks++;
        $display("FAIL done88_unexpected at cycle %0d: got done, want no pending op", cyc);
      end else begin
        exp_t e;
        e = q88.pop_front();
        chk("product88", 64'(prod88), 64'(e.prod));
        chk("done88_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // 8/4: 4 RUN steps; a start pulse mid-RUN must be ignored.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit noise);
    int c;
    c = cyc;
    a8 = av; b8 = bv; start8 = 1'b1;
    q8.push_back('{prod: 32'(av) * 32'(bv), cyc: c + 5});
    $display("op8  a=0x%02h b=0x%02h expect 0x%04h at cycle %0d", av, bv, 32'(av) * 32'(bv), c + 5);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start8 = (k == 1) ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      if (noise) begin a8 = 8'($urandom); b8 = 8'($urandom); end
      chk("busy8_run", 64'(busy8), 64'd1);
      chk("sel_a8", 64'(sela8), 64'(k / 2));
      chk("sel_b8", 64'(selb8), 64'(k % 2));
      chk("shift_sel8", 64'(shift8), 64'(k / 2 + k % 2));
    end
    @(negedge clk);
    start8 = 1'b0;
    chk("busy8_done", 64'(busy8), 64'd1);
    chk("shift_sel8_done", 64'(shift8), 64'd0);
    @(negedge clk);
    chk("busy8_idle", 64'(busy8), 64'd0);
  endtask

  task automatic op12(input logic [11:0] av, input logic [11:0] bv);
    int c;
    c = cyc;
    a12 = av; b12 = bv; start12 = 1'b1;
    q12.push_back('{prod: 32'(av) * 32'(bv), cyc: c + 10});
    $display("op12 a=0x%03h b=0x%03h expect 0x%06h at cycle %0d", av, bv, 32'(av) * 32'(bv), c + 10);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      start12 = 1'b0;
      a12 = 12'($urandom); b12 = 12'($urandom);
      chk("sel_a12", 64'(sela12), 64'(k / 3));
      chk("sel_b12", 64'(selb12), 64'(k % 3));
      chk("shift_sel12", 64'(shift12), 64'(k / 3 + k % 3));
    end
    @(negedge clk);
    chk("busy12_done", 64'(busy12), 64'd1);
    @(negedge clk);
    chk("busy12_idle", 64'(busy12), 64'd0);
  endtask

  task automatic op88(input logic [7:0] av, input logic [7:0] bv);
    int c;
    c = cyc;
    a88 = av; b88 = bv; start88 = 1'b1;
    q88.push_back('{prod: 32'(av) * 32'(bv), cyc: c + 2});
    $display("op88 a=0x%02h b=0x%02h expect 0x%04h at cycle %0d", av, bv, 32'(av) * 32'(bv), c + 2);
    @(negedge clk);
    start88 = 1'b0;
    chk("busy88_run", 64'(busy88), 64'd1);
    @(negedge clk);
    chk("busy88_done", 64'(busy88), 64'd1);
    @(negedge clk);
    chk("busy88_idle", 64'(busy88), 64'd0);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start12 = 1'b0; a12 = '0; b12 = '0;
    start88 = 1'b0; a88 = '0; b88 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy8", 64'(busy8), 64'd0);
    chk("reset_done8", 64'(done8), 64'd0);
    chk("reset_product8", 64'(prod8), 64'd0);
    chk("reset_sel8", 64'({sela8, selb8, shift8}), 64'd0);
    chk("reset_product12", 64'(prod12), 64'd0);
    chk("reset_busy88", 64'(busy88), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    op8(8'hFF, 8'hFF, 1'b0);
    op8(8'h00, 8'h5A, 1'b0);
    op12(12'hABC, 12'h123);
    op88(8'h80, 8'h02);

    // start held high: back-to-back operations every 6 cycles
    c = cyc;
    a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q8.push_back('{prod: 32'h0000_03A8, cyc: c + 5 + 6 * i});
      $display("op8  held a=0x12 b=0x34 expect 0x03a8 at cycle %0d", c + 5 + 6 * i);
    end
    repeat (13) @(negedge clk);
    start8 = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_idle_busy8", 64'(busy8), 64'd0);

    // reset in the middle of RUN aborts without a done pulse
    c = cyc;
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("abort8 reset at cycle %0d", c + 3);
    chk("abort_busy8", 64'(busy8), 64'd0);
    chk("abort_product8", 64'(prod8), 64'd0);
    chk("abort_shift_sel8", 64'(shift8), 64'd0);
    repeat (6) @(negedge clk);
    chk("abort_still_idle8", 64'(busy8), 64'd0);
    op8(8'h03, 8'h05, 1'b0);

    for (int i = 0; i < 12; i++) begin
      op8(8'($urandom), 8'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op12(12'($urandom), 12'($urandom));
      op88(8'($urandom), 8'($urandom));
    end
    op8(8'hFF, 8'h01, 1'b1);
    op12(12'hFFF, 12'hFFF);
    op88(8'hFF, 8'hFF);

    repeat (4) @(negedge clk);
    chk("pending8", 64'(q8.size()), 64'd0);
    chk("pending12", 64'(q12.size()), 64'd0);
    chk("pending88", 64'(q88.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
